// File: rtl/computation_sequencer_if.sv
// rtl/computation_sequencer_if.sv - host command and engine strobe/result signals of computation_sequencer
interface computation_sequencer_if;
  logic       start;
  logic [1:0] mode;
  logic       load;
  logic       busy;
  logic       result_valid;
  logic       timeout;
  logic       cmd_err;
  logic       active_store;
  logic       active_single;
  logic       active_sa3;
  logic       active_sa2;
  logic       done_store;
  logic       done_single;
  logic       done_sa3;
  logic       done_sa2;
  logic [7:0] c11, c12, c21, c22;
  logic [7:0] res_c11, res_c12, res_c21, res_c22;

  modport master (
    output start, mode, load, done_store, done_single, done_sa3, done_sa2,
           c11, c12, c21, c22,
    input  busy, result_valid, timeout, cmd_err,
           active_store, active_single, active_sa3, active_sa2,
           res_c11, res_c12, res_c21, res_c22
  );

  modport slave (
    input  start, mode, load, done_store, done_single, done_sa3, done_sa2,
           c11, c12, c21, c22,
    output busy, result_valid, timeout, cmd_err,
           active_store, active_single, active_sa3, active_sa2,
           res_c11, res_c12, res_c21, res_c22
  );
endinterface

// File: rtl/computation_sequencer.sv
// rtl/computation_sequencer.sv - store/gap/compute strobe sequencer with watchdog for computation_module
// Optional CYCLE_COUNT_EN adds last_cycles (acceptance-to-result_valid cycle count).
module computation_sequencer #(
  parameter int GAP_CYCLES     = 3,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CW             = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  computation_sequencer_if.slave bus
`ifdef CYCLE_COUNT_EN
  ,
  output logic [15:0]            last_cycles
`endif
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] STORE   = 2'd1;
  localparam logic [1:0] GAP     = 2'd2;
  localparam logic [1:0] COMPUTE = 2'd3;

  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

  logic [1:0]    state;
  logic [1:0]    mode_q;
  logic [CW-1:0] cnt;
  logic          done_sel;
  logic          wd_expired;

  always_comb begin
    case (mode_q)
      2'b00:   done_sel = bus.done_single;
      2'b01:   done_sel = bus.done_sa3;
      default: done_sel = bus.done_sa2;
    endcase
  end

  assign wd_expired = (cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      mode_q            <= 2'b00;
      cnt               <= '0;
      bus.busy          <= 1'b0;
      bus.result_valid  <= 1'b0;
      bus.timeout       <= 1'b0;
      bus.cmd_err       <= 1'b0;
      bus.active_store  <= 1'b0;
      bus.active_single <= 1'b0;
      bus.active_sa3    <= 1'b0;
      bus.active_sa2    <= 1'b0;
      bus.res_c11       <= '0;
      bus.res_c12       <= '0;
      bus.res_c21       <= '0;
      bus.res_c22       <= '0;
    end else begin
      bus.result_valid <= 1'b0;
      bus.timeout      <= 1'b0;
      bus.cmd_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.mode == 2'b11) begin
              bus.cmd_err <= 1'b1;
            end else begin
              mode_q   <= bus.mode;
              bus.busy <= 1'b1;
              cnt      <= '0;
              if (bus.load) begin
                state            <= STORE;
                bus.active_store <= 1'b1;
              end else begin
                state             <= COMPUTE;
                bus.active_single <= (bus.mode == 2'b00);
                bus.active_sa3    <= (bus.mode == 2'b01);
                bus.active_sa2    <= (bus.mode == 2'b10);
              end
            end
          end
        end
        STORE: begin
          if (bus.done_store) begin
            bus.active_store <= 1'b0;
            cnt              <= '0;
            if (GAP_CYCLES == 0) begin
              state             <= COMPUTE;
              bus.active_single <= (mode_q == 2'b00);
              bus.active_sa3    <= (mode_q == 2'b01);
              bus.active_sa2    <= (mode_q == 2'b10);
            end else begin
              state <= GAP;
            end
          end else if (wd_expired) begin
            bus.active_store <= 1'b0;
            bus.timeout      <= 1'b1;
            bus.busy         <= 1'b0;
            state            <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          // the compute strobe rises on the edge that ends the last gap cycle
          if (cnt == GAP_LAST) begin
            state             <= COMPUTE;
            cnt               <= '0;
            bus.active_single <= (mode_q == 2'b00);
            bus.active_sa3    <= (mode_q == 2'b01);
            bus.active_sa2    <= (mode_q == 2'b10);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          // done takes priority over a watchdog expiring on the same cycle
          if (done_sel) begin
            bus.active_single <= 1'b0;
            bus.active_sa3    <= 1'b0;
            bus.active_sa2    <= 1'b0;
            bus.res_c11       <= bus.c11;
            bus.res_c12       <= bus.c12;
            bus.res_c21       <= bus.c21;
            bus.res_c22       <= bus.c22;
            bus.result_valid  <= 1'b1;
            bus.busy          <= 1'b0;
            state             <= IDLE;
          end else if (wd_expired) begin
            bus.active_single <= 1'b0;
            bus.active_sa3    <= 1'b0;
            bus.active_sa2    <= 1'b0;
            bus.timeout       <= 1'b1;
            bus.busy          <= 1'b0;
            state             <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef CYCLE_COUNT_EN
  logic [15:0] run_cycles;

  // run_cycles holds the 1-based index of the current busy cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cycles  <= '0;
      last_cycles <= '0;
    end else if (state == IDLE) begin
      run_cycles <= 16'd1;
    end else begin
      if (run_cycles != 16'hFFFF) run_cycles <= run_cycles + 16'd1;
      if (state == COMPUTE && done_sel)
        last_cycles <= (run_cycles == 16'hFFFF) ? run_cycles : run_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: doc/computation_sequencer.md
Name: computation_sequencer

Overview:
- Command-level controller in front of computation_module (4x4 8-bit A, 3x3 8-bit B, 2x2 8-bit C; store/single/sa3/sa2 engines).
- Accepts one start command with mode and load flag, then drives the level-held active_* strobes in order: optional store, idle gap, one compute engine.
- Holds each strobe until the matching done_* is sampled, latches C, and reports completion or timeout to the host.
- Replaces hand-sequenced active_* stimulus; sits between the host/register block and computation_module.

Parameters:
- GAP_CYCLES, 3, idle cycles (all active_* low) between store completion and compute strobe; legal range 0..15.
- TIMEOUT_CYCLES, 255, max cycles an active_* may stay high without its done_*; legal range 1..65535.
- CW, 16, width of the watchdog/gap counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  command strobe, sampled only when busy=0
- mode  in  2  00=single, 01=sa3, 10=sa2, 11=reserved
- load  in  1  1: run store phase before compute
- busy  out  1  command in progress
- result_valid  out  1  one-cycle pulse, res_c* updated
- timeout  out  1  one-cycle pulse, watchdog expired
- cmd_err  out  1  one-cycle pulse, start with mode=11
- active_store  out  1  to computation_module
- active_single  out  1  to computation_module
- active_sa3  out  1  to computation_module
- active_sa2  out  1  to computation_module
- done_store  in  1  from computation_module
- done_single  in  1  from computation_module
- done_sa3  in  1  from computation_module
- done_sa2  in  1  from computation_module
- c11, c12, c21, c22  in  8 each  result from computation_module
- res_c11, res_c12, res_c21, res_c22  out  8 each  latched result

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, named rst.
- Registers: all outputs are registered.
- Reset: state IDLE; all active_*, busy, result_valid, timeout and cmd_err are 0; res_c* = 0; counters = 0.
- States: IDLE, STORE, GAP, COMPUTE.
- IDLE:
  - start=1, mode!=11, load=1 -> STORE; active_store=1 and busy=1 on the next edge.
  - start=1, mode!=11, load=0 -> COMPUTE; the selected active_* goes high on the next edge.
  - start=1, mode=11 -> stay IDLE; cmd_err pulses 1 cycle.
- mode and load are latched at acceptance. Changes while busy have no effect.
- start while busy=1 is ignored; nothing is queued.
- STORE:
  - active_store is held high.
  - On the edge done_store is sampled 1: active_store=0 and state -> GAP (or -> COMPUTE if GAP_CYCLES=0).
- GAP: exactly GAP_CYCLES cycles with every active_* low, then -> COMPUTE. The selected active_* rises on the edge leaving GAP.
- COMPUTE:
  - Exactly one of active_single/sa3/sa2 is held high.
  - On the edge its done is sampled 1, in the same edge: active_*=0, res_c* <= c*, result_valid=1, busy=0, state -> IDLE.
  - result_valid clears on the following edge.
- Done filtering: only the done matching the current phase is acted on. Other done_* inputs are ignored.
- Watchdog:
  - The counter clears on every strobe rise and counts each cycle an active_* is high.
  - Reaching TIMEOUT_CYCLES without the matching done: drop active_*, pulse timeout, set busy=0, go to IDLE.
  - res_c* is unchanged and no result_valid is issued.
- Simultaneous events: if done and timeout hit on the same cycle, done wins (normal completion).
- Back-to-back: start sampled in the cycle result_valid=1 is accepted (state is IDLE).
- Mutual exclusion: at most one active_* is high in any cycle.
- Reset mid-operation: on the next edge all active_* are 0, state IDLE, busy 0, and any pending pulse is cancelled. res_c* returns to 0.

Optional Feature:
- Macro CYCLE_COUNT_EN.
- Defined:
  - Adds output last_cycles (16 bits, reset 0).
  - Loaded with the number of cycles from command acceptance to result_valid (inclusive), on the same edge result_valid is set.
  - The count saturates at 16'hFFFF and is unchanged on timeout.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Store+single: A rows all {1,2,3,4}, B rows {1,1,1},{2,2,2},{3,3,3}; start with load=1, mode=00 -> active_store, 3-cycle low gap, then active_single held until done_single; res_c11=36, res_c12=54, res_c21=36, res_c22=54; result_valid pulses once.
- Compute-only: after the above, start with load=0, mode=01, then mode=10 back-to-back -> no active_store; each run gives results 36/54/36/54 and one result_valid each.
- Reserved mode: start with mode=11 -> cmd_err pulses 1 cycle; busy stays 0; all active_* stay 0.
- Timeout: model holds done_sa2=0, TIMEOUT_CYCLES=20 -> active_sa2 is high exactly 20 cycles, then timeout pulses; res_c* holds its previous values; busy=0.
- Reset mid-compute: assert rst 5 cycles into active_single -> next edge all active_* are 0, busy=0, res_c*=0; a fresh start afterwards completes normally.
- Spurious done: pulse done_sa3 during the store phase and during GAP -> no state change; gap length is still 3 and the sequence completes correctly.
